// File: rtl/bus_sequencer.sv
// Common-bus microsequencer: expands one register-transfer command into up to
// three timed steps driving bus source select, one-hot load strobes and ALU op.
module bus_sequencer #(
  parameter int unsigned IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_src,
  input  logic [2:0]       cmd_dst,
  input  logic [IMM_W-1:0] cmd_imm,
  output logic [2:0]       bus_sel,
  output logic [IMM_W-1:0] imm_out,
  output logic [5:0]       ld,
  output logic [1:0]       alu_op,
  output logic [1:0]       T,
  output logic             done,
  output logic             err
);

  localparam int unsigned LD_W = 6;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OUT  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_SWAP = 3'b111;

  localparam logic [2:0] SEL_DR  = 3'd5;
  localparam logic [2:0] SEL_IMM = 3'd6;
  localparam logic [2:0] SEL_ALU = 3'd7;

  localparam logic [LD_W-1:0] LD_AC   = 6'b001000;
  localparam logic [LD_W-1:0] LD_DR   = 6'b010000;
  localparam logic [LD_W-1:0] LD_OUTR = 6'b100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       t_q, t_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       src_q, src_d;
  logic [2:0]       dst_q, dst_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [2:0]       bus_sel_q;
  logic             illegal_c;
  logic [1:0]       last_t_c;

  function automatic logic [LD_W-1:0] onehot(input logic [2:0] code);
    return LD_W'(6'd1 << code);
  endfunction

  // State register and latched command fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      t_q       <= 2'd0;
      op_q      <= 3'd0;
      src_q     <= 3'd0;
      dst_q     <= 3'd0;
      imm_q     <= '0;
      bus_sel_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      bus_sel_q <= bus_sel;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && en && rst;
  assign imm_out   = imm_q;
  assign T         = t_q;

  always_comb begin
    illegal_c = 1'b0;
    if (cmd_op != OP_NOP && (cmd_src == 3'd4 || cmd_src == 3'd7))
      illegal_c = 1'b1;
    if ((cmd_op == OP_MOV || cmd_op == OP_LDI || cmd_op == OP_SWAP) && cmd_dst > 3'd3)
      illegal_c = 1'b1;
    if (cmd_op == OP_SWAP && cmd_src > 3'd3)
      illegal_c = 1'b1;
  end

  always_comb begin
    case (op_q)
      OP_ADD, OP_SUB, OP_AND: last_t_c = 2'd2;
      OP_SWAP:                last_t_c = 2'd3;
      default:                last_t_c = 2'd1;
    endcase
  end

  // Next-state logic; a stalled sequencer (en low) holds everything
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          imm_d = cmd_imm;
          if (illegal_c) begin
            state_d = S_ERR;
            t_d     = 2'd0;
          end else begin
            state_d = S_EXEC;
            t_d     = 2'd1;
          end
        end
      end
      S_EXEC: begin
        if (en) begin
          if (t_q == last_t_c) begin
            state_d = S_IDLE;
            t_d     = 2'd0;
          end else begin
            t_d = 2'(t_q + 2'd1);
          end
        end
      end
      S_ERR: begin
        if (en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = 2'd0;
      end
    endcase
  end

  // Step decode; bus_sel falls back to its previous value outside EXEC
  always_comb begin
    bus_sel = bus_sel_q;
    ld      = '0;
    alu_op  = 2'b00;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_EXEC: begin
        case (op_q)
          OP_NOP: done = 1'b1;
          OP_MOV: begin
            bus_sel = src_q;
            ld      = onehot(dst_q);
            done    = 1'b1;
          end
          OP_LDI: begin
            bus_sel = SEL_IMM;
            ld      = onehot(dst_q);
            done    = 1'b1;
          end
          OP_OUT: begin
            bus_sel = src_q;
            ld      = LD_OUTR;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            if (t_q == 2'd1) begin
              bus_sel = src_q;
              ld      = LD_DR;
            end else begin
              bus_sel = SEL_ALU;
              ld      = LD_AC;
              done    = 1'b1;
              case (op_q)
                OP_ADD:  alu_op = 2'b01;
                OP_SUB:  alu_op = 2'b10;
                default: alu_op = 2'b11;
              endcase
            end
          end
          default: begin
            case (t_q)
              2'd1: begin
                bus_sel = src_q;
                ld      = LD_DR;
              end
              2'd2: begin
                bus_sel = dst_q;
                ld      = onehot(src_q);
              end
              default: begin
                bus_sel = SEL_DR;
                ld      = onehot(dst_q);
                done    = 1'b1;
              end
            endcase
          end
        endcase
        if (!en) begin
          ld   = '0;
          done = 1'b0;
        end
      end
      S_ERR:   err = en;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: hand-computed step outputs per command.
module tb_bus_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_src;
  logic [2:0] cmd_dst;
  logic [7:0] cmd_imm;
  logic [2:0] bus_sel;
  logic [7:0] imm_out;
  logic [5:0] ld;
  logic [1:0] alu_op;
  logic [1:0] T;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  bus_sequencer #(.IMM_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_imm   (cmd_imm),
    .bus_sel   (bus_sel),
    .imm_out   (imm_out),
    .ld        (ld),
    .alu_op    (alu_op),
    .T         (T),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge, then scramble the fields to show they are ignored
  task automatic issue(input logic [2:0] op, input logic [2:0] src,
                       input logic [2:0] dst, input logic [7:0] imm);
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'b111;
    cmd_src   = 3'd7;
    cmd_dst   = 3'd7;
    cmd_imm   = 8'hFF;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_imm = 8'h00;
    #7;
    chk("rst_T", 32'(T), 32'd0);
    chk("rst_ld", 32'(ld), 32'd0);
    chk("rst_bus_sel", 32'(bus_sel), 32'd0);
    chk("rst_imm", 32'(imm_out), 32'd0);
    chk("rst_alu", 32'(alu_op), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // MOV R2 <- AC
    issue(3'b001, 3'd3, 3'd1, 8'h00);
    chk("mov_T", 32'(T), 32'd1);
    chk("mov_bus", 32'(bus_sel), 32'd3);
    chk("mov_ld", 32'(ld), 32'b000010);
    chk("mov_done", 32'(done), 32'd1);
    chk("mov_ready_busy", 32'(cmd_ready), 32'd0);
    tick();
    chk("mov_ready_after", 32'(cmd_ready), 32'd1);
    chk("mov_idle_T", 32'(T), 32'd0);
    chk("mov_idle_ld", 32'(ld), 32'd0);
    chk("mov_bus_hold", 32'(bus_sel), 32'd3);

    // ADD src=R1
    issue(3'b010, 3'd0, 3'd0, 8'h00);
    chk("add_t1_bus", 32'(bus_sel), 32'd0);
    chk("add_t1_ld", 32'(ld), 32'b010000);
    chk("add_t1_done", 32'(done), 32'd0);
    tick();
    chk("add_t2_T", 32'(T), 32'd2);
    chk("add_t2_bus", 32'(bus_sel), 32'd7);
    chk("add_t2_alu", 32'(alu_op), 32'd1);
    chk("add_t2_ld", 32'(ld), 32'b001000);
    chk("add_t2_done", 32'(done), 32'd1);
    tick();
    chk("add_ready", 32'(cmd_ready), 32'd1);
    chk("add_alu_idle", 32'(alu_op), 32'd0);

    // SWAP R1 <-> R3, then back-to-back LDI R2 <- 0xA5
    issue(3'b111, 3'd0, 3'd2, 8'h00);
    chk("swap_t1_bus", 32'(bus_sel), 32'd0);
    chk("swap_t1_ld", 32'(ld), 32'b010000);
    tick();
    chk("swap_t2_bus", 32'(bus_sel), 32'd2);
    chk("swap_t2_ld", 32'(ld), 32'b000001);
    tick();
    chk("swap_t3_T", 32'(T), 32'd3);
    chk("swap_t3_bus", 32'(bus_sel), 32'd5);
    chk("swap_t3_ld", 32'(ld), 32'b000100);
    chk("swap_t3_done", 32'(done), 32'd1);
    cmd_op = 3'b110; cmd_src = 3'd0; cmd_dst = 3'd1; cmd_imm = 8'hA5;
    cmd_valid = 1'b1;
    #1;
    chk("swap_t3_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("ldi_wait_ready", 32'(cmd_ready), 32'd1);
    chk("ldi_wait_T", 32'(T), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("ldi_T", 32'(T), 32'd1);
    chk("ldi_bus", 32'(bus_sel), 32'd6);
    chk("ldi_imm", 32'(imm_out), 32'hA5);
    chk("ldi_ld", 32'(ld), 32'b000010);
    chk("ldi_done", 32'(done), 32'd1);
    tick();

    // Illegal: MOV dst=5, then OUT src=7
    issue(3'b001, 3'd0, 3'd5, 8'h00);
    chk("ill_mov_err", 32'(err), 32'd1);
    chk("ill_mov_ld", 32'(ld), 32'd0);
    chk("ill_mov_T", 32'(T), 32'd0);
    chk("ill_mov_done", 32'(done), 32'd0);
    tick();
    chk("ill_mov_err_clr", 32'(err), 32'd0);
    chk("ill_mov_ready", 32'(cmd_ready), 32'd1);
    issue(3'b101, 3'd7, 3'd0, 8'h00);
    chk("ill_out_err", 32'(err), 32'd1);
    chk("ill_out_ld", 32'(ld), 32'd0);
    tick();
    chk("ill_out_err_clr", 32'(err), 32'd0);
    chk("ill_out_ready", 32'(cmd_ready), 32'd1);

    // Legal OUT and NOP
    issue(3'b101, 3'd3, 3'd0, 8'h00);
    chk("out_bus", 32'(bus_sel), 32'd3);
    chk("out_ld", 32'(ld), 32'b100000);
    chk("out_done", 32'(done), 32'd1);
    tick();
    issue(3'b000, 3'd4, 3'd6, 8'h00);
    chk("nop_T", 32'(T), 32'd1);
    chk("nop_ld", 32'(ld), 32'd0);
    chk("nop_done", 32'(done), 32'd1);
    chk("nop_err", 32'(err), 32'd0);
    tick();

    // en low in IDLE blocks acceptance
    en = 1'b0;
    cmd_op = 3'b001; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_valid = 1'b1;
    #1;
    chk("stall_idle_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("stall_idle_T", 32'(T), 32'd0);
    chk("stall_idle_ld", 32'(ld), 32'd0);
    cmd_valid = 1'b0;
    en = 1'b1;
    #1;
    chk("stall_idle_ready_back", 32'(cmd_ready), 32'd1);

    // SUB src=R2 with en low for three T1 cycles
    issue(3'b011, 3'd1, 3'd0, 8'h00);
    en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_T", 32'(T), 32'd1);
      chk("stall_ld", 32'(ld), 32'd0);
      chk("stall_bus", 32'(bus_sel), 32'd1);
      chk("stall_done", 32'(done), 32'd0);
      if (i < 2) tick();
    end
    en = 1'b1;
    #1;
    chk("resume_t1_T", 32'(T), 32'd1);
    chk("resume_t1_ld", 32'(ld), 32'b010000);
    tick();
    chk("resume_t2_T", 32'(T), 32'd2);
    chk("resume_t2_bus", 32'(bus_sel), 32'd7);
    chk("resume_t2_alu", 32'(alu_op), 32'd2);
    chk("resume_t2_ld", 32'(ld), 32'b001000);
    chk("resume_t2_done", 32'(done), 32'd1);
    tick();
    chk("resume_ready", 32'(cmd_ready), 32'd1);

    // Reset in the middle of SWAP R2 <-> R1
    issue(3'b111, 3'd1, 3'd0, 8'h00);
    chk("rswap_t1_ld", 32'(ld), 32'b010000);
    tick();
    chk("rswap_t2_ld", 32'(ld), 32'b000010);
    #2;
    rst = 1'b0;
    #1;
    chk("rswap_async_ld", 32'(ld), 32'd0);
    chk("rswap_async_T", 32'(T), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rswap_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("rswap_no_ld", 32'(ld), 32'd0);
    chk("rswap_T_idle", 32'(T), 32'd0);
    chk("rswap_no_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
